// File: rtl/alu.sv
// rtl/alu.sv - RV32I execute-stage ALU with combinational result/rd-write and a registered copy
package alu_pkg;
  typedef logic [31:0] data_t;
  typedef logic [31:0] instr_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
endpackage

module alu
  import alu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  instr_t instr,
  input  data_t  a_in,
  input  data_t  b_in,
  output data_t  c_out,
  output logic   rd_wr,
  output data_t  c_out_q,
  output logic   rd_wr_q
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic [4:0] shamt;
  data_t      alu_res;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign alt    = instr[30];
  assign shamt  = b_in[4:0];

  // Shared by OP and OP-IMM; SUB exists only in the register form.
  always_comb begin
    alu_res = '0;
    unique case (funct3)
      3'b000:  alu_res = (alt && opcode == OPC_OP) ? a_in - b_in : a_in + b_in;
      3'b001:  alu_res = a_in << shamt;
      3'b010:  alu_res = {31'b0, $signed(a_in) < $signed(b_in)};
      3'b011:  alu_res = {31'b0, a_in < b_in};
      3'b100:  alu_res = a_in ^ b_in;
      3'b101:  alu_res = alt ? data_t'($signed(a_in) >>> shamt) : a_in >> shamt;
      3'b110:  alu_res = a_in | b_in;
      default: alu_res = a_in & b_in;
    endcase
  end

  always_comb begin
    c_out = '0;
    rd_wr = 1'b0;
    unique case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        c_out = alu_res;
        rd_wr = 1'b1;
      end
      OPC_LUI: begin
        c_out = b_in;
        rd_wr = 1'b1;
      end
      OPC_AUIPC, OPC_LOAD: begin
        c_out = a_in + b_in;
        rd_wr = 1'b1;
      end
      OPC_STORE: begin
        c_out = a_in + b_in;
      end
      OPC_JAL, OPC_JALR: begin
        c_out = a_in + 32'd4;
        rd_wr = 1'b1;
      end
      default: begin
        c_out = '0;
        rd_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_out_q <= '0;
      rd_wr_q <= 1'b0;
    end else begin
      c_out_q <= c_out;
      rd_wr_q <= rd_wr;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized self-checking bench for alu against an arithmetic reference model
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] c_out;
  logic        rd_wr;
  logic [31:0] c_out_q;
  logic        rd_wr_q;

  int checks;
  int failures;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .instr   (instr),
    .a_in    (a_in),
    .b_in    (b_in),
    .c_out   (c_out),
    .rd_wr   (rd_wr),
    .c_out_q (c_out_q),
    .rd_wr_q (rd_wr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, results reduced modulo 2^32.
  function automatic logic [31:0] model_c(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
    longint la, lb, p2;
    int     sh;
    logic [31:0] r;
    la = longint'(a);
    lb = longint'(b);
    sh = int'(b % 32);
    p2 = longint'(1) << sh;
    r  = 32'h0;
    case (ins[6:0])
      7'h33, 7'h13: begin
        case (ins[14:12])
          3'd0: if (ins[6:0] == 7'h33 && ins[30])
                  r = 32'((la + (64'h1_0000_0000 - lb)) % 64'h1_0000_0000);
                else
                  r = 32'((la + lb) % 64'h1_0000_0000);
          3'd1: r = 32'((la * p2) % 64'h1_0000_0000);
          3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          3'd3: r = (la < lb) ? 32'd1 : 32'd0;
          3'd4: r = a ^ b;
          3'd5: begin
            r = 32'(la / p2);
            if (ins[30] && a[31]) r = r + 32'((64'h1_0000_0000 - 64'h1_0000_0000 / p2) % 64'h1_0000_0000);
          end
          3'd6: r = a | b;
          default: r = a & b;
        endcase
      end
      7'h37: r = b;
      7'h17, 7'h03, 7'h23: r = 32'((la + lb) % 64'h1_0000_0000);
      7'h6F, 7'h67: r = 32'((la + 4) % 64'h1_0000_0000);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic model_wr(input logic [31:0] ins);
    case (ins[6:0])
      7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h6F, 7'h67: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instr = ins;
    a_in  = a;
    b_in  = b;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(32'h00208033, 32'd7, 32'd9);
    checks++;
    if (c_out_q !== 32'h0) begin
      failures++;
      $display("FAIL reset_c_out_q got=%h exp=%h", c_out_q, 32'h0);
    end
    checks++;
    if (rd_wr_q !== 1'b0) begin
      failures++;
      $display("FAIL reset_rd_wr_q got=%b exp=0", rd_wr_q);
    end
  endtask

  task automatic test_rtype();
    logic [31:0] ops [5] = '{32'h00208033, 32'h40208033, 32'h0020F033, 32'h0020E033, 32'h0020C033};
    logic [31:0] a, b, e;
    foreach (ops[k]) begin
      for (int i = 0; i < 10000; i++) begin
        a = $urandom;
        b = $urandom;
        apply(ops[k], a, b);
        e = model_c(ops[k], a, b);
        checks++;
        if (c_out !== e || rd_wr !== 1'b1) begin
          failures++;
          $display("FAIL rtype ins=%h a=%h b=%h got=%h/%b exp=%h/1", ops[k], a, b, c_out, rd_wr, e);
        end
      end
    end
    apply(32'h00208033, 32'hFFFFFFFF, 32'h1);
    checks++;
    if (c_out !== 32'h0) begin
      failures++;
      $display("FAIL add_wrap got=%h exp=00000000", c_out);
    end
    apply(32'h40208033, 32'h0, 32'h1);
    checks++;
    if (c_out !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL sub_wrap got=%h exp=ffffffff", c_out);
    end
  endtask

  task automatic test_compare();
    logic [31:0] a, b, e;
    apply(32'h0020A033, 32'hFFFFFFFF, 32'h1);
    checks++;
    if (c_out !== 32'h1) begin
      failures++;
      $display("FAIL slt_neg got=%h exp=00000001", c_out);
    end
    apply(32'h0020B033, 32'hFFFFFFFF, 32'h1);
    checks++;
    if (c_out !== 32'h0) begin
      failures++;
      $display("FAIL sltu_big got=%h exp=00000000", c_out);
    end
    a = $urandom;
    apply(32'h0020A033, a, a);
    checks++;
    if (c_out !== 32'h0) begin
      failures++;
      $display("FAIL slt_eq got=%h exp=00000000", c_out);
    end
    apply(32'h0020B033, a, a);
    checks++;
    if (c_out !== 32'h0) begin
      failures++;
      $display("FAIL sltu_eq got=%h exp=00000000", c_out);
    end
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ins;
      ins = (i % 2 == 0) ? 32'h0020A033 : 32'h0020B033;
      a = $urandom;
      b = (i % 5 == 0) ? {~a[31], a[30:0]} : $urandom;
      apply(ins, a, b);
      e = model_c(ins, a, b);
      checks++;
      if (c_out !== e) begin
        failures++;
        $display("FAIL cmp ins=%h a=%h b=%h got=%h exp=%h", ins, a, b, c_out, e);
      end
    end
  endtask

  task automatic test_shift();
    logic [31:0] sops [3] = '{32'h00209033, 32'h0020D033, 32'h4020D033};
    logic [31:0] fixed [3] = '{32'h00000000, 32'h08000000, 32'hF8000000};
    logic [31:0] a, b, e;
    foreach (sops[k]) begin
      apply(sops[k], 32'h80000000, 32'hFFFFFFE4);
      checks++;
      if (c_out !== fixed[k]) begin
        failures++;
        $display("FAIL shift4 ins=%h got=%h exp=%h", sops[k], c_out, fixed[k]);
      end
      for (int i = 0; i < 200; i++) begin
        a = $urandom;
        b = {$urandom_range(0, 32'h07FF_FFFF), (i % 2 == 0) ? 5'd0 : 5'd31};
        apply(sops[k], a, b);
        e = model_c(sops[k], a, b);
        checks++;
        if (c_out !== e) begin
          failures++;
          $display("FAIL shift_edge ins=%h a=%h b=%h got=%h exp=%h", sops[k], a, b, c_out, e);
        end
      end
    end
  endtask

  task automatic test_other();
    logic [6:0]  opcs [12] = '{7'h13, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67,
                               7'h63, 7'h7F, 7'h0B, 7'h33};
    logic [31:0] ins, a, b, e;
    apply(32'h40000013, 32'd5, 32'd3);
    checks++;
    if (c_out !== 32'd8 || rd_wr !== 1'b1) begin
      failures++;
      $display("FAIL addi_bit30 got=%h/%b exp=00000008/1", c_out, rd_wr);
    end
    apply(32'h000000B7, $urandom, 32'h12345000);
    checks++;
    if (c_out !== 32'h12345000 || rd_wr !== 1'b1) begin
      failures++;
      $display("FAIL lui got=%h/%b exp=12345000/1", c_out, rd_wr);
    end
    apply(32'h0000006F, 32'h100, $urandom);
    checks++;
    if (c_out !== 32'h104 || rd_wr !== 1'b1) begin
      failures++;
      $display("FAIL jal got=%h/%b exp=00000104/1", c_out, rd_wr);
    end
    apply(32'h00000023, 32'h10, 32'h4);
    checks++;
    if (c_out !== 32'h14 || rd_wr !== 1'b0) begin
      failures++;
      $display("FAIL store got=%h/%b exp=00000014/0", c_out, rd_wr);
    end
    apply(32'h00208063, $urandom, $urandom);
    checks++;
    if (c_out !== 32'h0 || rd_wr !== 1'b0) begin
      failures++;
      $display("FAIL branch got=%h/%b exp=00000000/0", c_out, rd_wr);
    end
    for (int i = 0; i < 6000; i++) begin
      ins = {$urandom} & 32'hFFFF_FF80;
      ins[6:0] = opcs[i % 12];
      a = $urandom;
      b = $urandom;
      apply(ins, a, b);
      e = model_c(ins, a, b);
      checks++;
      if (c_out !== e || rd_wr !== model_wr(ins)) begin
        failures++;
        $display("FAIL mixed ins=%h a=%h b=%h got=%h/%b exp=%h/%b", ins, a, b, c_out, rd_wr, e,
                 model_wr(ins));
      end
    end
  endtask

  task automatic test_registers();
    logic [31:0] ins, a, b, e;
    logic        ew;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h00208033, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    checks++;
    if (c_out_q !== 32'd5 || rd_wr_q !== 1'b1) begin
      failures++;
      $display("FAIL reg_add got=%h/%b exp=00000005/1", c_out_q, rd_wr_q);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (c_out_q !== 32'h0 || rd_wr_q !== 1'b0) begin
      failures++;
      $display("FAIL reg_async_clear got=%h/%b exp=00000000/0", c_out_q, rd_wr_q);
    end
    checks++;
    if (c_out !== 32'd5 || rd_wr !== 1'b1) begin
      failures++;
      $display("FAIL comb_during_reset got=%h/%b exp=00000005/1", c_out, rd_wr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ins = (i % 3 == 0) ? 32'h00000023 : 32'h00208033 | ({$urandom} & 32'h4000_7000);
      a = $urandom;
      b = $urandom;
      apply(ins, a, b);
      e  = model_c(ins, a, b);
      ew = model_wr(ins);
      @(posedge clk);
      #1;
      checks++;
      if (c_out_q !== e || rd_wr_q !== ew) begin
        failures++;
        $display("FAIL reg_stream ins=%h got=%h/%b exp=%h/%b", ins, c_out_q, rd_wr_q, e, ew);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    instr    = 32'h0;
    a_in     = 32'h0;
    b_in     = 32'h0;
    test_reset();
    test_rtype();
    test_compare();
    test_shift();
    test_other();
    test_registers();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
